// File: rtl/location_commander_pkg.sv
// Shared definitions for the location-update command interface.
// Holds the angle ring size and distance limit defaults (also used by the
// location register), the commander state encoding and the command-line
// select encoding.
package location_commander_pkg;

  localparam int DEF_MODULO_VALUE   = 21;
  localparam int DEF_MAX_DIST_VALUE = 25;
  localparam int TIMER_W            = 4;

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    DRIVE,
    SETTLE,
    DONE,
    FAIL
  } state_t;

  typedef enum logic [2:0] {
    NONE,
    CETHA_PLUS,
    CETHA_MINUS,
    DIST_PLUS,
    DIST_MINUS
  } cmd_t;

endpackage

// File: rtl/location_commander_step_timer.sv
// step_timer: loadable down-counter with a terminal-count flag.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   load        - load loadValue this cycle (priority over counting)
//   loadValue   - value to load; tc rises loadValue+1 cycles after load
//   tc          - high while the count is zero
module step_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] loadValue,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/location_commander.sv
// location_commander: initiator side of the location-update command
// interface. Steps the location register toward a latched (angle, distance)
// target one unit per step, angle first, taking the shorter way around the
// angle ring, and re-reading feedback before every step.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   start                      - request a move (sampled only in IDLE)
//   target_cethaValue/distValue- requested angle / distance
//   cur_cethaValue/distValue   - feedback from the location register
//   isPlus/isMinus_*           - level command lines (one high at a time)
//   busy                       - move in progress
//   done / err                 - one-cycle completion / failure pulses
module location_commander
  import location_commander_pkg::*;
#(
  parameter int MODULO_VALUE   = DEF_MODULO_VALUE,
  parameter int MAX_DIST_VALUE = DEF_MAX_DIST_VALUE,
  parameter int HOLD_CYCLES    = 2,
  parameter int SETTLE_CYCLES  = 3,
  parameter int MAX_STEPS      = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] target_cethaValue,
  input  logic [4:0] target_distValue,
  input  logic [4:0] cur_cethaValue,
  input  logic [4:0] cur_distValue,
  output logic       isPlus_cethaValue,
  output logic       isMinus_cethaValue,
  output logic       isPlus_distValue,
  output logic       isMinus_distValue,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);

  // Forward distance around the ring; MODULO_VALUE is added first so the
  // 6-bit intermediate never goes negative.
  function automatic logic [5:0] angleDelta(input logic [4:0] tgt, input logic [4:0] cur);
    logic [5:0] sum;
    sum = {1'b0, tgt} + 6'(MODULO_VALUE) - {1'b0, cur};
    if (sum >= 6'(MODULO_VALUE)) begin
      sum = sum - 6'(MODULO_VALUE);
    end
    return sum;
  endfunction

  function automatic logic [4:0] clampDist(input logic [4:0] v);
    return (v > 5'(MAX_DIST_VALUE)) ? 5'(MAX_DIST_VALUE) : v;
  endfunction

  state_t              state, nextState;
  cmd_t                cmd, cmdNext, sel;
  logic [STEP_W-1:0]   stepCnt;
  logic [4:0]          tgtCetha, tgtDist;
  logic [5:0]          delta;
  logic                latchTarget, incStep;
  logic                timerLoad, timerTc;
  logic [TIMER_W-1:0]  timerValue;

  step_timer #(.W(TIMER_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timerLoad),
    .loadValue (timerValue),
    .tc        (timerTc)
  );

  // Step selection from the latched target and current feedback
  always_comb begin
    delta = angleDelta(tgtCetha, cur_cethaValue);
    sel   = NONE;
    if (delta != 6'd0) begin
      sel = (delta <= 6'(MODULO_VALUE / 2)) ? CETHA_PLUS : CETHA_MINUS;
    end else if (cur_distValue < tgtDist) begin
      sel = DIST_PLUS;
    end else if (cur_distValue > tgtDist) begin
      sel = DIST_MINUS;
    end
  end

  always_comb begin
    nextState   = state;
    cmdNext     = cmd;
    latchTarget = 1'b0;
    incStep     = 1'b0;
    timerLoad   = 1'b0;
    timerValue  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if ({1'b0, target_cethaValue} >= 6'(MODULO_VALUE)) begin
            nextState = FAIL;
          end else begin
            latchTarget = 1'b1;
            nextState   = EVAL;
          end
        end
      end
      EVAL: begin
        if (sel == NONE) begin
          nextState = DONE;
        end else if (stepCnt == STEP_W'(MAX_STEPS)) begin
          nextState = FAIL;
        end else begin
          cmdNext    = sel;
          incStep    = 1'b1;
          timerLoad  = 1'b1;
          timerValue = TIMER_W'(HOLD_CYCLES - 1);
          nextState  = DRIVE;
        end
      end
      DRIVE: begin
        if (timerTc) begin
          timerLoad  = 1'b1;
          timerValue = TIMER_W'(SETTLE_CYCLES - 1);
          nextState  = SETTLE;
        end
      end
      SETTLE: begin
        if (timerTc) begin
          nextState = EVAL;
        end
      end
      DONE:    nextState = IDLE;
      FAIL:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cmd     <= NONE;
      stepCnt <= '0;
    end else begin
      state <= nextState;
      cmd   <= cmdNext;
      if (latchTarget) begin
        stepCnt <= '0;
      end else if (incStep) begin
        stepCnt <= stepCnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (latchTarget) begin
      tgtCetha <= target_cethaValue;
      tgtDist  <= clampDist(target_distValue);
    end
  end

  // Outputs decode straight from state, so a reset clears them next cycle
  assign isPlus_cethaValue  = (state == DRIVE) && (cmd == CETHA_PLUS);
  assign isMinus_cethaValue = (state == DRIVE) && (cmd == CETHA_MINUS);
  assign isPlus_distValue   = (state == DRIVE) && (cmd == DIST_PLUS);
  assign isMinus_distValue  = (state == DRIVE) && (cmd == DIST_MINUS);
  assign busy               = (state != IDLE);
  assign done               = (state == DONE);
  assign err                = (state == FAIL);

endmodule

// File: tb/tb_location_commander.sv
// Directed bench for location_commander with a behavioural location
// register (edge-detecting, wrapping angle, saturating distance) as the
// feedback source.
module tb_location_commander;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [4:0] target_cethaValue = '0;
  logic [4:0] target_distValue = '0;
  logic [4:0] cur_cethaValue, cur_distValue;
  logic       isPlus_cethaValue, isMinus_cethaValue;
  logic       isPlus_distValue, isMinus_distValue;
  logic       busy, done, err;

  location_commander dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .target_cethaValue  (target_cethaValue),
    .target_distValue   (target_distValue),
    .cur_cethaValue     (cur_cethaValue),
    .cur_distValue      (cur_distValue),
    .isPlus_cethaValue  (isPlus_cethaValue),
    .isMinus_cethaValue (isMinus_cethaValue),
    .isPlus_distValue   (isPlus_distValue),
    .isMinus_distValue  (isMinus_distValue),
    .busy               (busy),
    .done               (done),
    .err                (err)
  );

  always #5 clk = ~clk;

  // Location register model
  logic [4:0] curC = '0, curD = '0;
  logic       loadReq = 1'b0, freeze = 1'b0;
  logic [4:0] loadC = '0, loadD = '0;
  logic [3:0] lines, prevLines = '0;
  int risePC = 0, riseMC = 0, risePD = 0, riseMD = 0, highPC = 0;
  int overlapCnt = 0, doneCnt = 0;

  assign cur_cethaValue = curC;
  assign cur_distValue  = curD;
  assign lines = {isPlus_cethaValue, isMinus_cethaValue, isPlus_distValue, isMinus_distValue};

  always @(posedge clk) begin
    if (loadReq) begin
      curC <= loadC;
      curD <= loadD;
    end else if (!freeze) begin
      if (lines[3] && !prevLines[3]) curC <= (curC == 5'd20) ? 5'd0 : curC + 5'd1;
      if (lines[2] && !prevLines[2]) curC <= (curC == 5'd0) ? 5'd20 : curC - 5'd1;
      if (lines[1] && !prevLines[1]) curD <= (curD < 5'd25) ? curD + 5'd1 : curD;
      if (lines[0] && !prevLines[0]) curD <= (curD > 5'd0) ? curD - 5'd1 : curD;
    end
    prevLines <= lines;
    if (lines[3] && !prevLines[3]) risePC <= risePC + 1;
    if (lines[2] && !prevLines[2]) riseMC <= riseMC + 1;
    if (lines[1] && !prevLines[1]) risePD <= risePD + 1;
    if (lines[0] && !prevLines[0]) riseMD <= riseMD + 1;
    if (lines[3]) highPC <= highPC + 1;
    if ($countones(lines) > 1) overlapCnt <= overlapCnt + 1;
    if (done) doneCnt <= doneCnt + 1;
  end

  int nVec = 0, nErr = 0;
  int bPC, bMC, bPD, bMD, bHigh, bDone;
  int cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic setLoc(input logic [4:0] c, input logic [4:0] d);
    loadC = c; loadD = d; loadReq = 1'b1;
    tick();
    loadReq = 1'b0;
  endtask

  task automatic snap();
    bPC = risePC; bMC = riseMC; bPD = risePD; bMD = riseMD;
    bHigh = highPC; bDone = doneCnt;
  endtask

  task automatic startMove(input logic [4:0] c, input logic [4:0] d);
    target_cethaValue = c; target_distValue = d; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges after the start-sampling edge until done or err shows
  task automatic waitEnd(input int bound, output int cycles);
    cycles = 0;
    while (!done && !err && cycles < bound) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    tick(); tick(); tick();
    check("rst_cmds", 32'(lines), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    reset = 1'b0;

    // (0,10) -> (3,10): three plus pulses, done 19 edges after start
    setLoc(5'd0, 5'd10); snap();
    startMove(5'd3, 5'd10);
    check("t1_busy", 32'(busy), 1);
    waitEnd(100, cyc);
    check("t1_cycles", cyc, 19);
    check("t1_done", 32'(done), 1);
    check("t1_err", 32'(err), 0);
    check("t1_plusC", risePC - bPC, 3);
    check("t1_highC", highPC - bHigh, 6);
    check("t1_minusC", riseMC - bMC, 0);
    tick();
    check("t1_busy_end", 32'(busy), 0);
    check("t1_done_end", 32'(done), 0);
    check("t1_cetha", 32'(curC), 3);
    check("t1_dist", 32'(curD), 10);

    // (0,10) -> (18,10): minus way round, with a start during busy ignored
    setLoc(5'd0, 5'd10); snap();
    startMove(5'd18, 5'd10);
    tick(); tick(); tick();
    startMove(5'd5, 5'd5);
    waitEnd(200, cyc);
    check("t2_cycles", cyc, 15);
    check("t2_done", 32'(done), 1);
    check("t2_minusC", riseMC - bMC, 3);
    check("t2_plusC", risePC - bPC, 0);
    check("t2_dist_lines", (risePD - bPD) + (riseMD - bMD), 0);
    tick();
    check("t2_cetha", 32'(curC), 18);
    check("t2_dist", 32'(curD), 10);

    // (5,10) -> (5,30): distance clamped to 25
    setLoc(5'd5, 5'd10); snap();
    startMove(5'd5, 5'd30);
    waitEnd(300, cyc);
    check("t3_cycles", cyc, 91);
    check("t3_done", 32'(done), 1);
    check("t3_plusD", risePD - bPD, 15);
    tick();
    check("t3_dist", 32'(curD), 25);
    check("t3_cetha", 32'(curC), 5);

    // (0,10) -> (10,10): d equals half the ring, still plus
    setLoc(5'd0, 5'd10); snap();
    startMove(5'd10, 5'd10);
    waitEnd(200, cyc);
    check("t4_cycles", cyc, 61);
    check("t4_plusC", risePC - bPC, 10);
    check("t4_minusC", riseMC - bMC, 0);
    tick();
    check("t4_cetha", 32'(curC), 10);

    // (20,3) -> (1,0): plus across the wrap, then distance down
    setLoc(5'd20, 5'd3); snap();
    startMove(5'd1, 5'd0);
    waitEnd(200, cyc);
    check("t5_cycles", cyc, 31);
    check("t5_plusC", risePC - bPC, 2);
    check("t5_minusD", riseMD - bMD, 3);
    tick();
    check("t5_cetha", 32'(curC), 1);
    check("t5_dist", 32'(curD), 0);

    // Illegal angle target
    snap();
    startMove(5'd21, 5'd10);
    check("t6_err", 32'(err), 1);
    check("t6_done", 32'(done), 0);
    check("t6_busy", 32'(busy), 1);
    tick();
    check("t6_busy_end", 32'(busy), 0);
    check("t6_err_end", 32'(err), 0);
    check("t6_lines", (risePC - bPC) + (riseMC - bMC) + (risePD - bPD) + (riseMD - bMD), 0);

    // Frozen feedback: step budget exhausted
    setLoc(5'd0, 5'd10); freeze = 1'b1; snap();
    startMove(5'd3, 5'd10);
    waitEnd(400, cyc);
    check("t7_cycles", cyc, 241);
    check("t7_err", 32'(err), 1);
    check("t7_done", 32'(done), 0);
    check("t7_plusC", risePC - bPC, 40);
    tick();
    freeze = 1'b0;
    check("t7_busy_end", 32'(busy), 0);
    check("t7_doneCnt", doneCnt - bDone, 0);

    // Reset during DRIVE
    setLoc(5'd0, 5'd10);
    startMove(5'd3, 5'd10);
    tick();
    check("t8_drive", 32'(isPlus_cethaValue), 1);
    reset = 1'b1;
    tick();
    check("t8_lines", 32'(lines), 0);
    check("t8_busy", 32'(busy), 0);
    check("t8_done", 32'(done), 0);
    check("t8_err", 32'(err), 0);
    reset = 1'b0;
    check("t8_cetha", 32'(curC), 1);
    startMove(5'd1, 5'd10);
    waitEnd(50, cyc);
    check("t8_restart_cycles", cyc, 1);
    check("t8_restart_done", 32'(done), 1);
    tick();

    check("overlap", overlapCnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/location_commander.md
Name: location_commander

Overview:
- Initiator side of the location-update command interface.
- Given a target (angle, distance), it drives the level command lines isPlus/isMinus_cethaValue and isPlus/isMinus_distValue.
- It watches the location register's cethaValue/distValue feedback and steps toward the target one unit at a time, taking the shortest way around the angle ring.
- It sits between game/input control logic and the location register. All command outputs are levels that the register edge-detects into one-cycle pulses.

Parameters:
- MODULO_VALUE, 21, angle ring size; legal angles 0..MODULO_VALUE-1.
- MAX_DIST_VALUE, 25, largest legal distance.
- HOLD_CYCLES, 2, cycles a command line is held high per step (>=1).
- SETTLE_CYCLES, 3, cycles with all command lines low after each step before feedback is re-compared (>=2).
- MAX_STEPS, 40, step budget per move before abort with error.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request a move; sampled only in IDLE
- target_cethaValue  in  5  requested angle
- target_distValue  in  5  requested distance
- cur_cethaValue  in  5  angle feedback from the location register
- cur_distValue  in  5  distance feedback from the location register
- isPlus_cethaValue  out  1  angle increment command (level)
- isMinus_cethaValue  out  1  angle decrement command (level)
- isPlus_distValue  out  1  distance increment command (level)
- isMinus_distValue  out  1  distance decrement command (level)
- busy  out  1  move in progress
- done  out  1  one-cycle pulse: target reached
- err  out  1  one-cycle pulse: illegal target or step budget exhausted

Behaviour:
- One clock, clk. Reset is synchronous and active-high; reset has priority over every other input.
- Reset values:
  - all four command outputs 0
  - busy 0, done 0, err 0
  - state IDLE, step counter 0
- Reset mid-move: outputs read 0 on the cycle after the reset edge, and no partial pulse is extended.
- States: IDLE, EVAL, DRIVE, SETTLE, DONE, FAIL.
- IDLE, on start=1:
  - If target_cethaValue >= MODULO_VALUE, go to FAIL.
  - Otherwise latch target_cethaValue, and latch target_distValue clamped to MAX_DIST_VALUE. Clear the step counter and go to EVAL.
- busy is 1 in every state except IDLE. start is ignored while busy=1.
- EVAL (1 cycle, all command outputs 0). Angle is resolved before distance.
  - Compute d = (target_ceta - cur_ceta) mod MODULO_VALUE, with no negative intermediate (add MODULO_VALUE before subtracting).
  - d != 0 and d <= MODULO_VALUE/2 (integer division): select isPlus_cethaValue.
  - d != 0 otherwise: select isMinus_cethaValue.
  - d == 0 and cur_dist < target_dist: select isPlus_distValue.
  - d == 0 and cur_dist > target_dist: select isMinus_distValue.
  - Both equal: go to DONE.
  - If the step counter == MAX_STEPS when a command would be selected, go to FAIL instead. Otherwise increment the counter and go to DRIVE.
- DRIVE: exactly one selected line is high for HOLD_CYCLES cycles, then go to SETTLE. Command lines are never two high at once.
- SETTLE: all lines low for SETTLE_CYCLES cycles, then go to EVAL. This guarantees a falling edge between consecutive pulses and gives the feedback time to update.
- Cost per step: 1 + HOLD_CYCLES + SETTLE_CYCLES cycles (6 at defaults).
- DONE: done=1 for one cycle, then IDLE. busy drops on the cycle after DONE.
- FAIL: err=1 for one cycle, then IDLE. done is never asserted together with err.
- Angle wrap: stepping from 0 with isMinus reaches MODULO_VALUE-1 via the register's own wrap. The commander never computes the wrapped value itself; it only re-reads feedback.
- Feedback changed externally mid-move: the next EVAL re-plans from the new value. MAX_STEPS bounds the move if feedback stops responding.
- All arithmetic is 6 bits wide internally, so MODULO_VALUE + 5-bit value cannot overflow.

Decomposition:
- Shared package:
  - MODULO_VALUE and MAX_DIST_VALUE defaults (also used by the location register)
  - state encoding
  - command select encoding: NONE, CETHA_PLUS, CETHA_MINUS, DIST_PLUS, DIST_MINUS
- One sub-module: step_timer, a loadable down-counter with a terminal-count flag, shared by DRIVE and SETTLE.

Test Plan (defaults; bench instantiates the location register as the feedback source):
- Start at (0,10) with target (3,10) -> exactly 3 isPlus_cethaValue pulses, each 2 cycles high, 6 cycles apart; done at cycle 19 after start; final (3,10).
- Start at (0,10) with target (18,10) -> d=18>10, so 3 isMinus_cethaValue pulses (0→20→19→18); no isPlus activity; done.
- Start at (5,10) with target (5,30) -> target clamped to 25; 15 isPlus_distValue pulses; done; distValue=25.
- target_cethaValue=21 -> err=1 on the cycle after start; no command line ever rises; busy returns to 0.
- Feedback frozen at (0,10) with target (3,10) -> 40 pulses, then err; done never asserted.
- Reset asserted during DRIVE -> next cycle all outputs 0 and state IDLE; a start pulse during busy is ignored (no re-latch).
